// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall, flush, halt detection and perf counters
// Two-state RUN/HALTED control; halt output freezes the fetch-stage PC.
module if_id_reg #(
  parameter int              A         = 4,
  parameter int              W         = 9,
  parameter logic [W-1:0]    HALT_INST = 9'h1FF,
  parameter int              C         = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [A-1:0] inst_addr,
  input  logic [W-1:0] inst_data,
  input  logic         stall,
  input  logic         flush,
  output logic [A-1:0] pc_out,
  output logic [W-1:0] inst_out,
  output logic         valid_out,
  output logic         halt,
  output logic [C-1:0] cycle_count,
  output logic [C-1:0] inst_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [C-1:0] CNT_MAX = {C{1'b1}};
  localparam logic [C-1:0] CNT_ONE = {{(C-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [W-1:0] inst_q, inst_d;
  logic         valid_q, valid_d;
  logic [C-1:0] cyc_q, cyc_d;
  logic [C-1:0] icnt_q, icnt_d;

  logic running;
  logic is_halt_word;
  logic do_flush;
  logic do_halt;
  logic do_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush and stall both mask halt detection; a stalled halt word is caught on release.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && !flush && !stall && inst_data == HALT_INST) begin
      state_d = HALTED;
    end
  end

  always_comb begin
    halt         = (state_q == HALTED);
    running      = (state_q == RUN);
    is_halt_word = (inst_data == HALT_INST);
    do_flush     = running && flush;
    do_halt      = running && !flush && !stall && is_halt_word;
    do_load      = running && !flush && !stall && !is_halt_word;
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (!running) begin
      valid_d = 1'b0;
    end
    if (do_flush) begin
      pc_d    = inst_addr;
      inst_d  = inst_data;
      valid_d = 1'b0;
    end
    // The halt word itself is never delivered; only its address is exposed.
    if (do_halt) begin
      pc_d    = inst_addr;
      valid_d = 1'b0;
    end
    if (do_load) begin
      pc_d    = inst_addr;
      inst_d  = inst_data;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    cyc_d  = cyc_q;
    icnt_d = icnt_q;
    if (running && cyc_q != CNT_MAX) begin
      cyc_d = cyc_q + CNT_ONE;
    end
    if (do_load && icnt_q != CNT_MAX) begin
      icnt_d = icnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      cyc_q   <= '0;
      icnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign inst_out    = inst_q;
  assign valid_out   = valid_q;
  assign cycle_count = cyc_q;
  assign inst_count  = icnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - scoreboard bench for if_id_reg (C=16 and saturating C=3 instances)
module tb_if_id_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] inst_addr;
  logic [8:0] inst_data;
  logic       stall;
  logic       flush;

  logic [3:0]  pc_out, s_pc_out;
  logic [8:0]  inst_out, s_inst_out;
  logic        valid_out, s_valid_out;
  logic        halt, s_halt;
  logic [15:0] cycle_count, inst_count;
  logic [2:0]  s_cycle_count, s_inst_count;

  if_id_reg #(.A(4), .W(9), .HALT_INST(9'h1FF), .C(16)) dut (
    .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst_data(inst_data),
    .stall(stall), .flush(flush), .pc_out(pc_out), .inst_out(inst_out),
    .valid_out(valid_out), .halt(halt), .cycle_count(cycle_count), .inst_count(inst_count)
  );

  if_id_reg #(.A(4), .W(9), .HALT_INST(9'h1FF), .C(3)) dut_s (
    .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst_data(inst_data),
    .stall(stall), .flush(flush), .pc_out(s_pc_out), .inst_out(s_inst_out),
    .valid_out(s_valid_out), .halt(s_halt), .cycle_count(s_cycle_count), .inst_count(s_inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pc;
    logic [8:0]  inst;
    logic        v;
    logic        h;
    logic [15:0] cyc;
    logic [15:0] ic;
    bit          cpc;
    bit          cinst;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_vec = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] sat7(input logic [15:0] x);
    return (x > 16'd7) ? 32'd7 : {16'd0, x};
  endfunction

  // Monitor: every edge the register presents a new state; pop and compare.
  int mon_idx = 0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.cpc)   chk("pc_out", mon_idx, {28'd0, pc_out}, {28'd0, e.pc});
      if (e.cinst) chk("inst_out", mon_idx, {23'd0, inst_out}, {23'd0, e.inst});
      chk("valid_out", mon_idx, {31'd0, valid_out}, {31'd0, e.v});
      chk("halt", mon_idx, {31'd0, halt}, {31'd0, e.h});
      chk("cycle_count", mon_idx, {16'd0, cycle_count}, {16'd0, e.cyc});
      chk("inst_count", mon_idx, {16'd0, inst_count}, {16'd0, e.ic});
      chk("sat_cycle_count", mon_idx, {29'd0, s_cycle_count}, sat7(e.cyc));
      chk("sat_inst_count", mon_idx, {29'd0, s_inst_count}, sat7(e.ic));
      chk("sat_halt", mon_idx, {31'd0, s_halt}, {31'd0, e.h});
      mon_idx++;
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input logic r, input logic [3:0] a, input logic [8:0] d,
                     input logic st, input logic fl,
                     input logic [3:0] epc, input logic [8:0] einst, input logic ev,
                     input logic eh, input logic [15:0] ecyc, input logic [15:0] eic,
                     input bit cpc, input bit cinst);
    exp_t e;
    reset = r; inst_addr = a; inst_data = d; stall = st; flush = fl;
    e.pc = epc; e.inst = einst; e.v = ev; e.h = eh; e.cyc = ecyc; e.ic = eic;
    e.cpc = cpc; e.cinst = cinst;
    q.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then run
    cyc(1, 4'd0, 9'h001, 0, 0,  4'd0, 9'h000, 0, 0, 16'd0, 16'd0, 1, 1);
    cyc(1, 4'd0, 9'h001, 0, 0,  4'd0, 9'h000, 0, 0, 16'd0, 16'd0, 1, 1);
    cyc(0, 4'd0, 9'h001, 0, 0,  4'd0, 9'h001, 1, 0, 16'd1, 16'd1, 1, 1);
    cyc(0, 4'd1, 9'h002, 0, 0,  4'd1, 9'h002, 1, 0, 16'd2, 16'd2, 1, 1);
    cyc(0, 4'd2, 9'h003, 0, 0,  4'd2, 9'h003, 1, 0, 16'd3, 16'd3, 1, 1);
    // Stall while pc_out = 1
    cyc(0, 4'd1, 9'h002, 0, 0,  4'd1, 9'h002, 1, 0, 16'd4, 16'd4, 1, 1);
    cyc(0, 4'd2, 9'h003, 1, 0,  4'd1, 9'h002, 1, 0, 16'd5, 16'd4, 1, 1);
    cyc(0, 4'd2, 9'h003, 1, 0,  4'd1, 9'h002, 1, 0, 16'd6, 16'd4, 1, 1);
    cyc(0, 4'd2, 9'h003, 0, 0,  4'd2, 9'h003, 1, 0, 16'd7, 16'd5, 1, 1);
    // Flush at addr 3, redirect to 8
    cyc(0, 4'd3, 9'h004, 0, 1,  4'd3, 9'h004, 0, 0, 16'd8, 16'd5, 1, 0);
    cyc(0, 4'd8, 9'h0A5, 0, 0,  4'd8, 9'h0A5, 1, 0, 16'd9, 16'd6, 1, 1);
    // Flush and stall together: flush wins
    cyc(0, 4'd9, 9'h011, 1, 1,  4'd9, 9'h011, 0, 0, 16'd10, 16'd6, 0, 0);
    cyc(0, 4'd10, 9'h022, 0, 0, 4'd10, 9'h022, 1, 0, 16'd11, 16'd7, 1, 1);
    // Wrong-path halt under flush
    cyc(0, 4'd11, 9'h1FF, 0, 1, 4'd11, 9'h1FF, 0, 0, 16'd12, 16'd7, 0, 0);
    cyc(0, 4'd12, 9'h033, 0, 0, 4'd12, 9'h033, 1, 0, 16'd13, 16'd8, 1, 1);
    // Halt word under stall, detected on release
    cyc(0, 4'd13, 9'h1FF, 1, 0, 4'd12, 9'h033, 1, 0, 16'd14, 16'd8, 1, 1);
    cyc(0, 4'd13, 9'h1FF, 0, 0, 4'd13, 9'h000, 0, 1, 16'd15, 16'd8, 1, 0);
    cyc(0, 4'd14, 9'h044, 0, 1, 4'd13, 9'h000, 0, 1, 16'd15, 16'd8, 1, 0);
    cyc(0, 4'd14, 9'h044, 1, 0, 4'd13, 9'h000, 0, 1, 16'd15, 16'd8, 1, 0);
    // Reset while halted, then halt at addr 4
    cyc(1, 4'd0, 9'h001, 0, 0,  4'd0, 9'h000, 0, 0, 16'd0, 16'd0, 1, 1);
    cyc(0, 4'd3, 9'h004, 0, 0,  4'd3, 9'h004, 1, 0, 16'd1, 16'd1, 1, 1);
    cyc(0, 4'd4, 9'h1FF, 0, 0,  4'd4, 9'h000, 0, 1, 16'd2, 16'd1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 4'd5, 9'h006, 0, logic'(i % 2), 4'd4, 9'h000, 0, 1, 16'd2, 16'd1, 1, 0);
    end
    // Saturation run: the C=3 instance stops at 7
    cyc(1, 4'd0, 9'h001, 0, 0,  4'd0, 9'h000, 0, 0, 16'd0, 16'd0, 1, 1);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 4'(k - 1), 9'(k), 0, 0, 4'(k - 1), 9'(k), 1, 0, 16'(k), 16'(k), 1, 1);
    end
    cyc(0, 4'd10, 9'h1FF, 0, 0, 4'd10, 9'h000, 0, 1, 16'd11, 16'd10, 1, 0);
    // Reset while halted and stalled clears everything and drops halt
    cyc(1, 4'd11, 9'h055, 1, 0, 4'd0, 9'h000, 0, 0, 16'd0, 16'd0, 1, 1);
    cyc(0, 4'd0, 9'h001, 0, 0,  4'd0, 9'h001, 1, 0, 16'd1, 16'd1, 1, 1);

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0 || mon_idx != n_vec) begin
      n_bad++;
      $display("FAIL drain: checked %0d of %0d vectors, %0d left", mon_idx, n_vec, q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/if_id_reg.md
# if_id_reg

Pipeline register between the instruction-fetch stage and decode. Each cycle it samples the fetch address and the asynchronous instruction-ROM word for that address. It presents them to decode with a valid bit. It handles stall, flush-on-taken-branch and halt detection, and keeps saturating cycle and retired-instruction counters for benchmark reporting. It also produces the `halt` signal that freezes the fetch stage's PC register.

## Interface
- `A`, 4, instruction address width; matches the fetch stage PC width.
- `W`, 9, instruction word width.
- `HALT_INST`, 9'h1FF, encoding of the halt instruction.
- `C`, 16, width of both performance counters.

- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `inst_addr`  in  A  current PC from the fetch stage.
- `inst_data`  in  W  ROM word at `inst_addr`; combinational, valid in the same cycle.
- `stall`  in  1  decode/hazard stall; hold the register contents.
- `flush`  in  1  taken branch resolved downstream (`ctrl_branch && take_branch`); squash the fetched word.
- `pc_out`  out  A  registered address of the instruction in the register.
- `inst_out`  out  W  registered instruction word.
- `valid_out`  out  1  `inst_out` is a real instruction, not a bubble.
- `halt`  out  1  registered; high means the processor is halted; drives the fetch stage `halt`.
- `cycle_count`  out  C  cycles spent in RUN.
- `inst_count`  out  C  instructions delivered with `valid_out` = 1.

## Operation
- Two states: RUN and HALTED. `halt` = (state == HALTED).
- Priority at each posedge is reset > HALTED > flush > stall > halt-detect > normal load.
- **reset**
  - state ← RUN.
  - `pc_out`, `inst_out`, `valid_out`, both counters ← 0.
  - `halt` ← 0.
- **HALTED**
  - `valid_out` ← 0.
  - `pc_out` and `inst_out` hold.
  - Counters hold.
  - `stall` and `flush` are ignored.
  - The only exit is reset.
- **flush (RUN)**
  - `valid_out` ← 0.
  - `pc_out` ← `inst_addr`, `inst_out` ← `inst_data` (don't-care contents).
  - The fetched word is never halt-detected.
- **stall (RUN, no flush)**
  - Register and `valid_out` hold.
  - `inst_count` holds.
- **halt-detect (RUN, no flush, no stall, `inst_data` == `HALT_INST`)**
  - state ← HALTED.
  - `valid_out` ← 0; the halt instruction is not delivered and not counted.
  - `pc_out` ← `inst_addr`, so the halt PC is observable.
- **normal load (RUN)**
  - `pc_out` ← `inst_addr`, `inst_out` ← `inst_data`, `valid_out` ← 1.
- **`cycle_count`**
  - Increments on every posedge in RUN (including stall and flush cycles) except the reset edge.
  - Saturates at 2^C−1; no wrap.
- **`inst_count`**
  - Increments on each normal load.
  - Saturates at 2^C−1.
- Counter arithmetic is C-bit unsigned; saturation is checked before increment.

## Timing
- Latency: word at `inst_addr` in cycle n appears on `inst_out` with `valid_out` = 1 in cycle n+1.
- Halt:
  - `HALT_INST` fetched in cycle n gives `halt` = 1 from cycle n+1.
  - The fetch stage advances once more at the n+1 edge, then freezes.
  - No further `valid_out` pulses occur.
- Flush in cycle n gives a bubble in cycle n+1. The redirected target is loaded normally at the n+1 edge.
- First cycle after reset: `valid_out` = 0. The fetch stage presents the reset address, which appears at the output one cycle later.
- Flush and stall in the same cycle: flush wins; the bubble is inserted.
- Flush coincident with `HALT_INST` on `inst_data`: flush wins and no halt occurs (wrong-path halt).
- Stall coincident with `HALT_INST`: no halt that cycle. Detection happens when the stall releases, with the same word still present.
- Reset while HALTED or mid-stall: everything returns to reset values at that edge.

## Test plan
- **Reset then run.** Reset for 2 cycles, ROM 0:9'h001, 1:9'h002, 2:9'h003.
  - `valid_out` = 0 in the first post-reset cycle.
  - Then `pc_out`/`inst_out` = 0/001, 1/002, 2/003 on consecutive cycles.
  - `inst_count` = 3.
- **Stall.** Stall for 2 cycles while `pc_out` = 1.
  - `pc_out`/`inst_out` hold 1/002 with `valid_out` = 1.
  - `inst_count` unchanged; `cycle_count` +2.
- **Flush.** Flush while `inst_addr` = 3, then the fetch stage supplies addr 8.
  - Next cycle `valid_out` = 0.
  - The following cycle `pc_out` = 8, `valid_out` = 1.
- **Halt.** ROM 4 = 9'h1FF.
  - `halt` = 1 one cycle after addr 4 is presented.
  - `pc_out` = 4, `valid_out` = 0 thereafter.
  - Counters frozen over 10 further cycles; flush pulses ignored.
- **Wrong-path halt.** `HALT_INST` on `inst_data` with flush = 1, and separately with stall = 1 followed by release.
  - Flush case: no halt.
  - Stall case: halt asserts one cycle after the stall releases.
- **Saturation.** C=3, run 10 sequential instructions.
  - `inst_count` and `cycle_count` stop at 7.
  - Reset clears both to 0 and deasserts `halt`.
